// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lsu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 4;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Request fields captured at acceptance and held until the next one.
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        memop;
        logic [TAG_W-1:0]  rd;
    } req_t;

endpackage

// File: rtl/lsu_align_check.sv
// Flags a request whose MemOp is undefined, unstorable, or misaligned.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic [2:0] memop,
    input  logic [1:0] addr,
    input  logic       wen,
    output logic       illegal
);

    // Halfwords only fault when they straddle a word; unsigned ops are load-only.
    always_comb begin
        illegal = 1'b1;
        case (memop)
            MEMOP_B:  illegal = 1'b0;
            MEMOP_H:  illegal = (addr == 2'b11);
            MEMOP_HU: illegal = (addr == 2'b11) | wen;
            MEMOP_W:  illegal = (addr != 2'b00);
            MEMOP_BU: illegal = wen;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// One-at-a-time load/store sequencer between execute and data memory.
// Latency: legal request responds LATENCY+1 edges after accept (counting it), illegal one edge.
// Backpressure: req_ready low outside IDLE; response held until resp_ready.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_memop,
    input  logic [TAG_W-1:0]  req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_memop,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [TAG_W-1:0]  resp_rd,
    output logic              resp_err
);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    req_t             lat;
    logic             illegal;

    lsu_align_check u_check (
        .memop   (req_memop),
        .addr    (req_addr[1:0]),
        .wen     (req_wen),
        .illegal (illegal)
    );

    // The memory sees the latched request, so it cannot change mid-access.
    assign mem_addr  = lat.addr;
    assign mem_memop = lat.memop;
    assign mem_wdata = lat.wdata;

    // Request/access/response sequencer; all handshake and memory strobes are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat        <= '0;
            req_ready  <= 1'b1;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat       <= '{wen: req_wen, addr: req_addr, wdata: req_wdata,
                                       memop: req_memop, rd: req_rd};
                        req_ready <= 1'b0;
                        if (illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_rd    <= req_rd;
                        end else begin
                            state  <= ACCESS;
                            cnt    <= CNT_W'(LATENCY - 1);
                            mem_rd <= ~req_wen;
                            // Store strobe is set for the first access cycle only.
                            mem_wr <= req_wen;
                        end
                    end
                end
                ACCESS: begin
                    mem_wr <= 1'b0;
                    if (cnt == '0) begin
                        state      <= RESP;
                        mem_rd     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rd    <= lat.rd;
                        resp_rdata <= lat.wen ? '0 : mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Retiring cycle never also accepts; IDLE resumes next edge.
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam logic [31:0] MAGIC = 32'h5EAD_BEEB;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic [4:0]  req_rd;
    logic        resp_ready;

    logic        rdy1, mrd1, mwr1, rv1, rerr1;
    logic [31:0] maddr1, mwd1, rdat1, mrdata1;
    logic [2:0]  mop1;
    logic [4:0]  rrd1;
    logic        rdy3, mrd3, mwr3, rv3, rerr3;
    logic [31:0] maddr3, mwd3, rdat3, mrdata3;
    logic [2:0]  mop3;
    logic [4:0]  rrd3;

    logic        o_rdy, o_mrd, o_mwr, o_rv, o_rerr;
    logic [31:0] o_maddr, o_mwd, o_rdat;
    logic [2:0]  o_mop;
    logic [4:0]  o_rrd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory model: returned data is a fixed scramble of the address.
    assign mrdata1 = maddr1 ^ MAGIC;
    assign mrdata3 = maddr3 ^ MAGIC;

    lsu_ctrl #(.LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy1),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_memop(req_memop), .req_rd(req_rd),
        .mem_addr(maddr1), .mem_memop(mop1), .mem_wdata(mwd1),
        .mem_rd(mrd1), .mem_wr(mwr1), .mem_rdata(mrdata1),
        .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rdat1),
        .resp_rd(rrd1), .resp_err(rerr1)
    );

    lsu_ctrl #(.LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy3),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_memop(req_memop), .req_rd(req_rd),
        .mem_addr(maddr3), .mem_memop(mop3), .mem_wdata(mwd3),
        .mem_rd(mrd3), .mem_wr(mwr3), .mem_rdata(mrdata3),
        .resp_valid(rv3), .resp_ready(resp_ready), .resp_rdata(rdat3),
        .resp_rd(rrd3), .resp_err(rerr3)
    );

    always_comb begin
        o_rdy = sel ? rdy3 : rdy1;
        o_mrd = sel ? mrd3 : mrd1;
        o_mwr = sel ? mwr3 : mwr1;
        o_rv = sel ? rv3 : rv1;
        o_rerr = sel ? rerr3 : rerr1;
        o_maddr = sel ? maddr3 : maddr1;
        o_mwd = sel ? mwd3 : mwd1;
        o_rdat = sel ? rdat3 : rdat1;
        o_mop = sel ? mop3 : mop1;
        o_rrd = sel ? rrd3 : rrd1;
    end

    typedef struct {
        logic        lat3;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  memop;
        logic [4:0]  rd;
        logic        err;
        logic [31:0] rdata;
        int          edges;
        int          rd_cyc;
        int          wr_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          edges;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  memop;
    } exp_t;

    vec_t vecs[12];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(o_rdy), 32'd1);
        chk({tag, " mem_rd|mem_wr"}, 32'({o_mrd, o_mwr}), 32'd0);
        chk({tag, " resp_valid"}, 32'(o_rv), 32'd0);
        chk({tag, " resp_rdata"}, o_rdat, 32'd0);
        chk({tag, " resp_rd|err"}, 32'({o_rrd, o_rerr}), 32'd0);
        chk({tag, " mem_addr"}, o_maddr, 32'd0);
    endtask

    // Drive one request, then follow it to its response via the scoreboard.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   edges, rdc, wrc, w;
        sel = v.lat3;
        w = 0;
        #1;
        while (!o_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!o_rdy) chk($sformatf("v%0d ready timeout", idx), 32'(o_rdy), 32'd1);
        req_valid = 1'b1;
        req_wen   = v.wen;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_memop = v.memop;
        req_rd    = v.rd;
        exp_q.push_back('{v.rdata, v.rd, v.err, v.edges, v.rd_cyc, v.wr_cyc,
                          v.addr, v.wdata, v.memop});
        @(negedge clk);
        req_valid = 1'b0;
        edges = 1;
        rdc = 0;
        wrc = 0;
        while (!o_rv && edges < 40) begin
            if (o_mrd) rdc++;
            if (o_mwr) wrc++;
            @(negedge clk);
            edges++;
        end
        e = exp_q.pop_front();
        chk($sformatf("v%0d resp_valid", idx), 32'(o_rv), 32'd1);
        chk($sformatf("v%0d edges", idx), 32'(edges), 32'(e.edges));
        chk($sformatf("v%0d resp_rdata", idx), o_rdat, e.rdata);
        chk($sformatf("v%0d resp_err", idx), 32'(o_rerr), 32'(e.err));
        chk($sformatf("v%0d resp_rd", idx), 32'(o_rrd), 32'(e.rd));
        chk($sformatf("v%0d mem_rd cycles", idx), 32'(rdc), 32'(e.rd_cyc));
        chk($sformatf("v%0d mem_wr cycles", idx), 32'(wrc), 32'(e.wr_cyc));
        chk($sformatf("v%0d mem_addr", idx), o_maddr, e.addr);
        chk($sformatf("v%0d mem_wdata", idx), o_mwd, e.wdata);
        chk($sformatf("v%0d mem_memop", idx), 32'(o_mop), 32'(e.memop));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk($sformatf("v%0d retire resp_valid", idx), 32'(o_rv), 32'd0);
        chk($sformatf("v%0d retire req_ready", idx), 32'(o_rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        //            lat3  wen   addr          wdata         memop   rd     err   rdata         edg rd wr
        vecs[0]  = '{1'b0, 1'b0, 32'h8000_0004, 32'h0,        3'b010, 5'd5,  1'b0, 32'hDEAD_BEEF, 2, 1, 0};
        vecs[1]  = '{1'b1, 1'b1, 32'h8000_0003, 32'h0000_00AB, 3'b000, 5'd6, 1'b0, 32'h0,        4, 0, 1};
        vecs[2]  = '{1'b0, 1'b0, 32'h8000_0002, 32'h0,        3'b010, 5'd1,  1'b1, 32'h0,        1, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 32'h8000_0007, 32'h0000_1234, 3'b001, 5'd2, 1'b1, 32'h0,        1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,        3'b110, 5'd3,  1'b1, 32'h0,        1, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 32'h8000_0000, 32'h0000_0055, 3'b100, 5'd4, 1'b1, 32'h0,        1, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'h8000_0001, 32'h0,        3'b100, 5'd9,  1'b0, 32'hDEAD_BEEA, 4, 3, 0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_1001, 32'h0,        3'b001, 5'd31, 1'b0, 32'h5EAD_AEEA, 2, 1, 0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3'b010, 5'd12, 1'b0, 32'h0,       4, 0, 1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,        3'b101, 5'd10, 1'b1, 32'h0,        1, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        3'b011, 5'd11, 1'b1, 32'h0,        1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0,        3'b001, 5'd13, 1'b0, 32'h5EAD_BEE9, 4, 3, 0};

        rst = 1'b1;
        sel = 1'b0;
        req_valid = 1'b0;
        req_wen = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_memop = '0;
        req_rd = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_reset_outputs($sformatf("reset L%0d", s ? 3 : 1));
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Backpressured response: outputs frozen, no new request accepted.
        sel = 1'b0;
        req_valid = 1'b1;
        req_wen = 1'b0;
        req_addr = 32'h8000_0004;
        req_memop = 3'b010;
        req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            chk($sformatf("bp%0d resp_valid", c), 32'(o_rv), 32'd1);
            chk($sformatf("bp%0d resp_rdata", c), o_rdat, 32'hDEAD_BEEF);
            chk($sformatf("bp%0d resp_rd|err", c), 32'({o_rrd, o_rerr}), 32'({5'd7, 1'b0}));
            chk($sformatf("bp%0d req_ready", c), 32'(o_rdy), 32'd0);
            chk($sformatf("bp%0d mem_addr", c), o_maddr, 32'h8000_0004);
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp release resp_valid", 32'(o_rv), 32'd0);
        chk("bp release req_ready", 32'(o_rdy), 32'd1);

        // Reset in the second access cycle of a 3-cycle load.
        sel = 1'b1;
        req_valid = 1'b1;
        req_wen = 1'b0;
        req_addr = 32'h8000_0008;
        req_memop = 3'b010;
        req_rd = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid mem_rd before", 32'(o_mrd), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst-mid");
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_rv) seen = 1'b1;
        end
        resp_ready = 1'b0;
        chk("rst-mid no response", 32'(seen), 32'd0);
        chk("rst-mid req_ready", 32'(o_rdy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store controller between the execute stage and the data memory. It accepts one memory request at a time over a valid/ready handshake and checks MemOp legality and alignment. For legal requests it drives the memory's read/write controls for a fixed latency window, then holds a registered response until the consumer (write-back stage) accepts it. Illegal or misaligned requests skip the memory and return an error response.

## Interface
- `LATENCY`, default 1: memory access window in cycles, legal range 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_memop`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_rd`  in  5  destination register tag, returned unchanged.
- `mem_addr`  out  32  latched request address.
- `mem_memop`  out  3  latched MemOp.
- `mem_wdata`  out  32  latched store data.
- `mem_rd`  out  1  memory read enable.
- `mem_wr`  out  1  memory write enable.
- `mem_rdata`  in  32  extended load data from memory, combinational on `mem_addr`/`mem_memop`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_rd`  out  5  tag of the completed request.
- `resp_err`  out  1  request was illegal or misaligned.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch wen/addr/wdata/memop/rd and evaluate the check. Legal -> ACCESS with counter=LATENCY-1. Illegal -> RESP with err=1, rdata=0.
- Illegal when any of:
  - memop in {011,110,111};
  - store with memop 100/101;
  - H/HU with addr[1:0]=11;
  - W with addr[1:0]≠00.
- ACCESS, load: `mem_rd`=1 for every ACCESS cycle.
- ACCESS, store: `mem_wr`=1 in the first ACCESS cycle only, so the store is issued exactly once.
- ACCESS counter: decrements each cycle. In the cycle where the counter is 0:
  - loads capture `mem_rdata` into `resp_rdata`; stores capture 0;
  - state -> RESP.
- RESP: `resp_valid`=1. `resp_rdata`/`resp_rd`/`resp_err` are stable until `resp_ready`=1, then -> IDLE.
- `req_ready`=0 outside IDLE. No request is accepted in the same cycle a response retires.
- `mem_addr`/`mem_memop`/`mem_wdata` hold their latched values across ACCESS and RESP; they change only on acceptance.

## Timing
- Reset values: state IDLE; all outputs 0 except `req_ready`=1.
- Accept at edge N.
  - Legal request: ACCESS occupies cycles N+1..N+LATENCY. `resp_valid` rises after edge N+LATENCY. The earliest next accept is at edge N+LATENCY+2.
  - Illegal request: `resp_valid` rises after edge N. `mem_rd`/`mem_wr` never assert.
- A backpressured response (`resp_ready`=0) holds all resp outputs indefinitely.
- Reset asserted mid-ACCESS:
  - outputs drop immediately and no response is produced;
  - a store already issued in its first cycle is not retried or undone.
- Counter width is 4 bits. LATENCY=1 gives a single-cycle ACCESS.

## Structure
- `lsu_pkg` holds:
  - MemOp constants MEMOP_B/H/W/BU/HU;
  - the state enum (IDLE/ACCESS/RESP);
  - the width constants for address (32), data (32) and tag (5).
- Sub-module `lsu_align_check` is combinational. Inputs: memop, addr[1:0], wen. Output: `illegal`. It is instantiated once on the request inputs.
- The top level holds the FSM, counter, request latch and response register.

## Test plan
- Reset then W load, addr 0x80000004, LATENCY=1, memory returns 0xDEADBEEF:
  - `mem_rd` is high one cycle;
  - `resp_valid` appears 2 edges after accept with rdata 0xDEADBEEF, err=0 and rd echoed.
- B store, addr 0x80000003, wdata 0x000000AB, LATENCY=3:
  - `mem_wr` is high exactly one cycle while `mem_rd` stays 0;
  - the response arrives after 4 edges with rdata 0.
- Misaligned W load at 0x80000002, and H store at 0x80000007:
  - each gives a response the edge after accept, with err=1 and rdata 0;
  - `mem_rd`/`mem_wr` stay 0 throughout.
- Illegal memop 110 load, and BU store:
  - each gives err=1 with no memory activity.
- Response backpressure: hold `resp_ready`=0 for 5 cycles.
  - resp outputs stay stable and `req_ready` stays 0;
  - raising `resp_ready` returns to IDLE next edge.
- Assert `rst` in the second ACCESS cycle of a LATENCY=3 load:
  - all outputs go to reset values immediately and `req_ready`=1 after release;
  - no `resp_valid` ever appears for that request.
